// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state enum, opcodes,
// ALU/immediate/mux select codes and the per-state control table.
// Optional build macro ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        JALR     = 4'd10,
        LINKWB   = 4'd11,
        BRANCH   = 4'd12,
        LUI      = 4'd13
`ifdef ILLEGAL_TRAP_EN
        , TRAP   = 4'd14
`endif
    } statetype_t;

    // Which operation the ALU performs in a given state
    typedef enum logic [1:0] {
        ALUCLS_ADD = 2'd0,
        ALUCLS_SUB = 2'd1,
        ALUCLS_R   = 2'd2,
        ALUCLS_I   = 2'd3
    } aluclass_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // Moore control word; the branch PC enable is added outside this table
    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input statetype_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.pcwrite   = 1'b1;
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
                c.memwrite  = 1'b1;
            end
            EXECUTER: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_RS2;
            end
            EXECUTEI: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
            end
            ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
            end
            JAL: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALUOUT;
                c.pcwrite   = 1'b1;
            end
            JALR: begin
                c.alusrca   = SRCA_A;
                c.alusrcb   = SRCB_IMM;
                c.resultsrc = RES_ALURESULT;
                c.pcwrite   = 1'b1;
            end
            LINKWB: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
                c.regwrite  = 1'b1;
            end
            BRANCH: begin
                c.alusrca   = SRCA_A;
                c.alusrcb   = SRCB_RS2;
                c.resultsrc = RES_ALUOUT;
            end
            LUI: begin
                c.resultsrc = RES_IMMEXT;
                c.regwrite  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic aluclass_t state_aluclass(input statetype_t s);
        case (s)
            EXECUTER: return ALUCLS_R;
            EXECUTEI: return ALUCLS_I;
            BRANCH:   return ALUCLS_SUB;
            default:  return ALUCLS_ADD;
        endcase
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: fixed add/sub for address and compare states,
// funct3/funct7b5 decode for register and immediate arithmetic.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  aluclass_t  aluclass,
    output logic [3:0] alucontrol
);

    // Immediate forms never subtract: op5 is 0 for OP-IMM, so bit 30 of the immediate is ignored
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluclass)
            ALUCLS_SUB: alucontrol = ALU_SUB;
            ALUCLS_R, ALUCLS_I: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the shared-memory multicycle RV32I datapath.
// Outputs are registered from the next-state decode so each state's controls
// appear in the same cycle the state is active; write enables are masked while
// reset is high. Define ILLEGAL_TRAP_EN to park unknown opcodes in TRAP.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       cout,
    input  logic       overflow,
    input  logic       sign,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    statetype_t state, next_state;
    ctrl_t      ctrl_q, ctrl_next;
    logic [3:0] alucontrol_q, alucontrol_next;
    logic       branch_taken;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_q;
`endif

    // Next-state selection; DECODE dispatches on the latched opcode
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH: next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECUTER;
                    OP_ITYPE:          next_state = EXECUTEI;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_LUI:            next_state = LUI;
                    OP_AUIPC:          next_state = ALUWB;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = TRAP;
`else
                    default:           next_state = FETCH;
`endif
                endcase
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            JAL:      next_state = ALUWB;
            JALR:     next_state = LINKWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     next_state = TRAP;
`endif
            default:  next_state = FETCH;
        endcase
    end

    // Branch decision from the subtract flags of rs1 - rs2
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = ~Zero;
            3'b100:  branch_taken = sign ^ overflow;
            3'b101:  branch_taken = ~(sign ^ overflow);
            3'b110:  branch_taken = ~cout;
            3'b111:  branch_taken = cout;
            default: branch_taken = 1'b0;
        endcase
    end

    assign ctrl_next = state_ctrl(next_state);

    alu_decoder u_alu_decoder (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluclass   (state_aluclass(next_state)),
        .alucontrol (alucontrol_next)
    );

    // State register plus registered control word for the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            ctrl_q       <= state_ctrl(FETCH);
            alucontrol_q <= ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
            illegal_q    <= 1'b0;
`endif
        end else begin
            state        <= next_state;
            ctrl_q       <= ctrl_next;
            alucontrol_q <= alucontrol_next;
`ifdef ILLEGAL_TRAP_EN
            illegal_q    <= (next_state == TRAP);
`endif
        end
    end

    assign PCWrite    = ~reset & (ctrl_q.pcwrite | ((state == BRANCH) & branch_taken));
    assign IRWrite    = ~reset & ctrl_q.irwrite;
    assign RegWrite   = ~reset & ctrl_q.regwrite;
    assign MemWrite   = ~reset & ctrl_q.memwrite;
    assign AdrSrc     = ctrl_q.adrsrc;
    assign ResultSrc  = ctrl_q.resultsrc;
    assign ALUSrcA    = ctrl_q.alusrca;
    assign ALUSrcB    = ctrl_q.alusrcb;
    assign ALUControl = alucontrol_q;
    assign ImmSrc     = imm_src(op);
`ifdef ILLEGAL_TRAP_EN
    assign illegal    = illegal_q;
`else
    assign illegal    = 1'b0;
`endif

endmodule
